// File: rtl/vending_credit_fsm.sv
// Coin-credit vending controller: accumulates coin credit against a programmable price,
// vends at most one item per sale, pays exact change, and refunds on cancel or idle timeout.
module vending_credit_fsm #(
  parameter int unsigned COIN_A   = 5,
  parameter int unsigned COIN_B   = 10,
  parameter int unsigned PRICE    = 15,
  parameter int unsigned CREDIT_W = 6,
  parameter int unsigned TIMEOUT  = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                u_clk,
  input  logic                rst,
  input  logic [1:0]          coin_i,
  input  logic                cancel_i,
  output logic                vend_o,
  output logic                change_vld_o,
  output logic [CREDIT_W-1:0] change_amt_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                reject_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    sales_cnt_o
);

  localparam int unsigned SumW  = CREDIT_W + 1;
  localparam int unsigned IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StCollect, StDispense, StRefund} state_e;

  state_e              state_q, state_d;
  logic [IdleW-1:0]    idle_q, idle_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] amt_q, amt_d;
  logic [CNT_W-1:0]    sales_q, sales_d;
  logic                vend_q, vend_d;
  logic                cvld_q, cvld_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;

  logic                coin_valid;
  logic [SumW-1:0]     coin_val;
  logic [SumW-1:0]     sum;

  // Decode the coin code into a value; code 11 is worth nothing and is rejected below.
  always_comb begin
    coin_valid = 1'b0;
    coin_val   = '0;
    case (coin_i)
      2'b01: begin
        coin_valid = 1'b1;
        coin_val   = SumW'(COIN_A);
      end
      2'b10: begin
        coin_valid = 1'b1;
        coin_val   = SumW'(COIN_B);
      end
      default: ;
    endcase
  end

  // One extra bit so credit plus the largest coin never overflows.
  assign sum = {1'b0, credit_q} + coin_val;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    credit_d = credit_q;
    amt_d    = amt_q;
    sales_d  = sales_q;
    reject_d = (coin_i == 2'b11);

    unique case (state_q)
      StIdle: begin
        idle_d = '0;
        // cancel is meaningless with no credit, so it is ignored here
        if (coin_valid) begin
          if (sum >= SumW'(PRICE)) begin
            state_d  = StDispense;
            amt_d    = CREDIT_W'(sum - SumW'(PRICE));
            credit_d = '0;
            sales_d  = sales_q + CNT_W'(1);
          end else begin
            state_d  = StCollect;
            credit_d = CREDIT_W'(sum);
          end
        end
      end
      StCollect: begin
        if (cancel_i) begin
          // a coin arriving with cancel is accepted and then refunded with the rest
          state_d  = StRefund;
          amt_d    = CREDIT_W'(sum);
          credit_d = '0;
          idle_d   = '0;
        end else if (sum >= SumW'(PRICE)) begin
          state_d  = StDispense;
          amt_d    = CREDIT_W'(sum - SumW'(PRICE));
          credit_d = '0;
          idle_d   = '0;
          sales_d  = sales_q + CNT_W'(1);
        end else if (coin_valid) begin
          credit_d = CREDIT_W'(sum);
          idle_d   = '0;
        end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
          state_d  = StRefund;
          amt_d    = credit_q;
          credit_d = '0;
          idle_d   = '0;
        end else begin
          // invalid coins count as idle so they cannot hold off the timeout
          idle_d = idle_q + IdleW'(1);
        end
      end
      StDispense, StRefund: begin
        reject_d = (coin_i != 2'b00);
        credit_d = '0;
        idle_d   = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    vend_d = (state_d == StDispense);
    cvld_d = (state_d == StDispense) || (state_d == StRefund);
    busy_d = cvld_d;
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge u_clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idle_q   <= '0;
      credit_q <= '0;
      amt_q    <= '0;
      sales_q  <= '0;
      vend_q   <= 1'b0;
      cvld_q   <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      credit_q <= credit_d;
      amt_q    <= amt_d;
      sales_q  <= sales_d;
      vend_q   <= vend_d;
      cvld_q   <= cvld_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
    end
  end

  assign vend_o       = vend_q;
  assign change_vld_o = cvld_q;
  assign change_amt_o = amt_q;
  assign credit_o     = credit_q;
  assign reject_o     = reject_q;
  assign busy_o       = busy_q;
  assign sales_cnt_o  = sales_q;

endmodule

// File: tb/tb_vending_credit_fsm.sv
// Bench for vending_credit_fsm: directed sale scenarios plus random coins/cancels/resets
// compared cycle by cycle against a credit-ledger reference model.
module tb_vending_credit_fsm;

  localparam int unsigned COIN_A   = 5;
  localparam int unsigned COIN_B   = 10;
  localparam int unsigned PRICE    = 15;
  localparam int unsigned CREDIT_W = 6;
  localparam int unsigned TIMEOUT  = 8;
  localparam int unsigned CNT_W    = 8;

  logic                u_clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          coin = 2'b00;
  logic                cancel = 1'b0;
  logic                vend_o, change_vld_o, reject_o, busy_o;
  logic [CREDIT_W-1:0] change_amt_o, credit_o;
  logic [CNT_W-1:0]    sales_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: credit ledger, idle count, sales tally, and whether a payout is showing.
  int m_credit = 0;
  int m_idle = 0;
  int m_sales = 0;
  bit m_paying = 0;
  logic                e_vend, e_cvld, e_reject, e_busy;
  logic [CREDIT_W-1:0] e_amt, e_credit;
  logic [CNT_W-1:0]    e_sales;

  vending_credit_fsm #(
    .COIN_A(COIN_A), .COIN_B(COIN_B), .PRICE(PRICE),
    .CREDIT_W(CREDIT_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .u_clk       (u_clk),
    .rst         (rst),
    .coin_i      (coin),
    .cancel_i    (cancel),
    .vend_o      (vend_o),
    .change_vld_o(change_vld_o),
    .change_amt_o(change_amt_o),
    .credit_o    (credit_o),
    .reject_o    (reject_o),
    .busy_o      (busy_o),
    .sales_cnt_o (sales_cnt_o)
  );

  always #5 u_clk = ~u_clk;

  // Apply the sale rules to the inputs sampled at this edge.
  task automatic model_step();
    int v;
    e_vend = 0; e_cvld = 0; e_reject = 0;
    if (rst) begin
      m_credit = 0; m_idle = 0; m_sales = 0; m_paying = 0; e_amt = '0;
    end else begin
      v = (coin == 2'b01) ? COIN_A : (coin == 2'b10) ? COIN_B : 0;
      if (coin == 2'b11) e_reject = 1;
      if (m_paying) begin
        m_paying = 0;
        if (coin != 2'b00) e_reject = 1;
      end else if (m_credit > 0 && cancel) begin
        e_cvld = 1; e_amt = CREDIT_W'(m_credit + v); m_credit = 0; m_paying = 1;
      end else if (m_credit + v >= PRICE) begin
        e_vend = 1; e_cvld = 1; e_amt = CREDIT_W'(m_credit + v - PRICE);
        m_credit = 0; m_paying = 1; m_sales = (m_sales + 1) % (1 << CNT_W);
      end else if (v > 0) begin
        m_credit = m_credit + v; m_idle = 0;
      end else if (m_credit > 0) begin
        if (m_idle == TIMEOUT - 1) begin
          e_cvld = 1; e_amt = CREDIT_W'(m_credit); m_credit = 0; m_paying = 1; m_idle = 0;
        end else begin
          m_idle = m_idle + 1;
        end
      end
    end
    e_busy = m_paying;
    e_credit = CREDIT_W'(m_credit);
    e_sales = CNT_W'(m_sales);
  endtask

  // Drive one cycle of inputs, advance the model, and settle just past the edge.
  task automatic tick(input logic [1:0] c, input logic k, input logic r);
    coin = c; cancel = k; rst = r;
    @(posedge u_clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    tick(2'b00, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 1'b1);
    if ({vend_o, change_vld_o, change_amt_o, credit_o, reject_o, busy_o, sales_cnt_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got vend=%b cvld=%b amt=%0d credit=%0d rej=%b busy=%b sales=%0d want all 0",
               vend_o, change_vld_o, change_amt_o, credit_o, reject_o, busy_o, sales_cnt_o);
    end
    n_vec++;
  endtask

  task automatic test_exact_sale();
    tick(2'b00, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0);
    if (credit_o !== 6'd5) begin n_err++; $display("FAIL exact_credit5: got %0d want 5", credit_o); end
    n_vec++;
    tick(2'b01, 1'b0, 1'b0);
    if (credit_o !== 6'd10 || vend_o !== 1'b0) begin
      n_err++; $display("FAIL exact_credit10: got credit=%0d vend=%b want 10/0", credit_o, vend_o);
    end
    n_vec++;
    tick(2'b01, 1'b0, 1'b0);
    if ({vend_o, change_vld_o, busy_o} !== 3'b111 || change_amt_o !== 6'd0 || sales_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL exact_vend: got vend=%b cvld=%b busy=%b amt=%0d sales=%0d want 1/1/1/0/1",
               vend_o, change_vld_o, busy_o, change_amt_o, sales_cnt_o);
    end
    n_vec++;
    tick(2'b00, 1'b0, 1'b0);
    if ({vend_o, change_vld_o, busy_o} !== 3'b000 || credit_o !== 6'd0) begin
      n_err++; $display("FAIL exact_after: got vend=%b cvld=%b busy=%b credit=%0d want 0s",
                        vend_o, change_vld_o, busy_o, credit_o);
    end
    n_vec++;
  endtask

  task automatic test_change();
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0);
    if (vend_o !== 1'b1 || change_amt_o !== 6'd5 || sales_cnt_o !== 8'd2) begin
      n_err++; $display("FAIL change_vend: got vend=%b amt=%0d sales=%0d want 1/5/2",
                        vend_o, change_amt_o, sales_cnt_o);
    end
    n_vec++;
    tick(2'b00, 1'b0, 1'b0);
    if (credit_o !== 6'd0 || change_vld_o !== 1'b0 || change_amt_o !== 6'd5) begin
      n_err++; $display("FAIL change_after: got credit=%0d cvld=%b amt=%0d want 0/0/5",
                        credit_o, change_vld_o, change_amt_o);
    end
    n_vec++;
  endtask

  task automatic test_cancel();
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b01, 1'b1, 1'b0);
    if (change_vld_o !== 1'b1 || change_amt_o !== 6'd15 || vend_o !== 1'b0 || credit_o !== 6'd0) begin
      n_err++; $display("FAIL cancel_refund: got cvld=%b amt=%0d vend=%b credit=%0d want 1/15/0/0",
                        change_vld_o, change_amt_o, vend_o, credit_o);
    end
    n_vec++;
    tick(2'b00, 1'b1, 1'b0);
    if (change_vld_o !== 1'b0 || sales_cnt_o !== 8'd2) begin
      n_err++; $display("FAIL cancel_after: got cvld=%b sales=%0d want 0/2", change_vld_o, sales_cnt_o);
    end
    n_vec++;
  endtask

  task automatic test_timeout();
    int pulses = 0;
    tick(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick((i == 2) ? 2'b11 : 2'b00, 1'b0, 1'b0);
      if (change_vld_o) pulses++;
      if (i == 2 && reject_o !== 1'b1) begin
        n_err++; $display("FAIL timeout_reject: got %b want 1", reject_o);
      end
      if (i == 2) n_vec++;
      if (i < 7 && change_vld_o !== 1'b0) begin
        n_err++; $display("FAIL timeout_early: idle %0d got cvld=%b want 0", i + 1, change_vld_o);
      end
      if (i < 7) n_vec++;
    end
    if (change_vld_o !== 1'b1 || change_amt_o !== 6'd5 || vend_o !== 1'b0) begin
      n_err++; $display("FAIL timeout_refund: got cvld=%b amt=%0d vend=%b want 1/5/0",
                        change_vld_o, change_amt_o, vend_o);
    end
    n_vec++;
    tick(2'b00, 1'b0, 1'b0);
    if (change_vld_o) pulses++;
    if (pulses != 1) begin n_err++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
    n_vec++;
  endtask

  task automatic test_reject_and_rst();
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0);
    if (reject_o !== 1'b1 || credit_o !== 6'd0) begin
      n_err++; $display("FAIL dispense_reject: got rej=%b credit=%0d want 1/0", reject_o, credit_o);
    end
    n_vec++;
    tick(2'b00, 1'b0, 1'b0);
    if (reject_o !== 1'b0 || credit_o !== 6'd0) begin
      n_err++; $display("FAIL dispense_after: got rej=%b credit=%0d want 0/0", reject_o, credit_o);
    end
    n_vec++;
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b1);
    if ({vend_o, change_vld_o, change_amt_o, credit_o, reject_o, busy_o, sales_cnt_o} !== '0) begin
      n_err++; $display("FAIL midsale_rst: got cvld=%b amt=%0d credit=%0d sales=%0d want 0s",
                        change_vld_o, change_amt_o, credit_o, sales_cnt_o);
    end
    n_vec++;
  endtask

  task automatic test_random();
    int r;
    logic [1:0] c;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      c = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      tick(c, ($urandom_range(0, 5) == 0), ($urandom_range(0, 299) == 0));
      if ({vend_o, change_vld_o, change_amt_o, credit_o, reject_o, busy_o, sales_cnt_o} !==
          {e_vend, e_cvld, e_amt, e_credit, e_reject, e_busy, e_sales}) begin
        n_err++;
        $display("FAIL random[%0d]: got vend=%b cvld=%b amt=%0d credit=%0d rej=%b busy=%b sales=%0d want %b %b %0d %0d %b %b %0d",
                 i, vend_o, change_vld_o, change_amt_o, credit_o, reject_o, busy_o, sales_cnt_o,
                 e_vend, e_cvld, e_amt, e_credit, e_reject, e_busy, e_sales);
      end
      n_vec++;
    end
  endtask

  task automatic test_back_to_back_wrap();
    tick(2'b00, 1'b0, 1'b1);
    for (int s = 1; s <= 256; s++) begin
      tick(2'b10, 1'b0, 1'b0);
      tick(2'b01, 1'b0, 1'b0);
      if (vend_o !== 1'b1 || sales_cnt_o !== CNT_W'(s % 256) || sales_cnt_o !== e_sales) begin
        n_err++; $display("FAIL wrap_sale[%0d]: got vend=%b sales=%0d want 1/%0d", s, vend_o,
                          sales_cnt_o, s % 256);
      end
      n_vec++;
      tick(2'b00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_exact_sale();
    test_change();
    test_cancel();
    test_timeout();
    test_reject_and_rst();
    test_random();
    test_back_to_back_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
